// File: rtl/sb_scalar_tracker.sv
// sb_scalar_tracker: scalar scoreboard front end, register result status table plus per-FU row tracking
module sb_scalar_tracker #(
  parameter int NUM_FU = 3,
  parameter int NUM_REGS = 32,
  parameter int TAG_W = 2,
  localparam int FU_W = $clog2(NUM_FU)
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic                    dispatch_valid,
  input  logic [FU_W-1:0]         dispatch_fu,
  input  logic [4:0]              dispatch_rs1,
  input  logic [4:0]              dispatch_rs2,
  input  logic [4:0]              dispatch_rd,
  input  logic                    dispatch_rd_we,
  output logic                    dispatch_ready,
  output logic                    fust_en,
  output logic [FU_W-1:0]         fust_fu,
  output logic [NUM_FU-1:0]       busy,
  output logic [NUM_FU*TAG_W-1:0] t1,
  output logic [NUM_FU*TAG_W-1:0] t2,
  output logic [NUM_FU-1:0]       issue_valid,
  input  logic [NUM_FU-1:0]       issue_ack,
  input  logic [NUM_FU-1:0]       wb_valid,
  input  logic                    flush
);
  typedef enum logic [1:0] {IDLE, WAIT, READY, EXEC} row_t;
  row_t             state_q [NUM_FU];
  row_t             state_d [NUM_FU];
  logic [TAG_W-1:0] t1_q [NUM_FU];
  logic [TAG_W-1:0] t1_d [NUM_FU];
  logic [TAG_W-1:0] t2_q [NUM_FU];
  logic [TAG_W-1:0] t2_d [NUM_FU];
  logic [TAG_W-1:0] rst_q [NUM_REGS];
  logic [TAG_W-1:0] rst_d [NUM_REGS];
  logic [NUM_FU-1:0] wb_eff;
  logic [TAG_W-1:0]  src1, src2;
  logic              accept, inv_bad;
  // drop a tag whose producer writes back this cycle
  function automatic logic [TAG_W-1:0] wake(input logic [TAG_W-1:0] tag, input logic [NUM_FU-1:0] wb);
    wake = tag;
    for (int k = 0; k < NUM_FU; k++)
      if (wb[k] && tag == TAG_W'(k + 1)) wake = '0;
  endfunction
  always_comb begin
    for (int k = 0; k < NUM_FU; k++) wb_eff[k] = wb_valid[k] && state_q[k] == EXEC;
    dispatch_ready = 32'(dispatch_fu) < NUM_FU && state_q[dispatch_fu] == IDLE && !flush &&
                     !(dispatch_rd_we && dispatch_rd != '0 && rst_q[dispatch_rd] != '0);
    accept = dispatch_valid && dispatch_ready;
    fust_en = accept;
    fust_fu = dispatch_fu;
    src1 = wake(dispatch_rs1 == '0 ? '0 : rst_q[dispatch_rs1], wb_eff);
    src2 = wake(dispatch_rs2 == '0 ? '0 : rst_q[dispatch_rs2], wb_eff);
    for (int k = 0; k < NUM_FU; k++) begin
      t1_d[k] = wake(t1_q[k], wb_eff);
      t2_d[k] = wake(t2_q[k], wb_eff);
      state_d[k] = state_q[k];
      case (state_q[k])
        IDLE: if (accept && dispatch_fu == FU_W'(k)) begin
          t1_d[k] = src1;
          t2_d[k] = src2;
          state_d[k] = (src1 == '0 && src2 == '0) ? READY : WAIT;
        end
        WAIT: state_d[k] = (t1_d[k] == '0 && t2_d[k] == '0) ? READY : WAIT;
        READY: state_d[k] = issue_ack[k] ? EXEC : READY;
        default: state_d[k] = wb_eff[k] ? IDLE : EXEC;
      endcase
      if (flush) begin
        state_d[k] = IDLE;
        t1_d[k] = '0;
        t2_d[k] = '0;
      end
      busy[k] = state_q[k] != IDLE;
      issue_valid[k] = state_q[k] == READY;
      t1[k*TAG_W +: TAG_W] = t1_q[k];
      t2[k*TAG_W +: TAG_W] = t2_q[k];
    end
    for (int r = 0; r < NUM_REGS; r++) rst_d[r] = flush ? '0 : wake(rst_q[r], wb_eff);
    if (accept && dispatch_rd_we && dispatch_rd != '0) rst_d[dispatch_rd] = TAG_W'(dispatch_fu) + TAG_W'(1);
    inv_bad = 1'b0;
    for (int r = 0; r < NUM_REGS; r++)
      for (int k = 0; k < NUM_FU; k++)
        if (rst_q[r] == TAG_W'(k + 1) && state_q[k] == IDLE) inv_bad = 1'b1;
  end
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int k = 0; k < NUM_FU; k++) begin
        state_q[k] <= IDLE;
        t1_q[k] <= '0;
        t2_q[k] <= '0;
      end
      for (int r = 0; r < NUM_REGS; r++) rst_q[r] <= '0;
    end else begin
      state_q <= state_d;
      t1_q <= t1_d;
      t2_q <= t2_d;
      rst_q <= rst_d;
    end
  end
  for (genvar k = 0; k < NUM_FU; k++) begin : g_chk
    assert property (@(posedge CLK) disable iff (!nRST) wb_valid[k] |-> state_q[k] == EXEC);
    assert property (@(posedge CLK) disable iff (!nRST) issue_ack[k] |-> state_q[k] == READY);
  end
  assert property (@(posedge CLK) disable iff (!nRST) !inv_bad);
endmodule

// File: tb/tb_sb_scalar_tracker.sv
// tb_sb_scalar_tracker: randomized scoreboard bench against a register/producer map model
module tb_sb_scalar_tracker;
  logic       CLK = 1'b0, nRST = 1'b0;
  logic       dispatch_valid = 1'b0, dispatch_rd_we = 1'b0, flush = 1'b0;
  logic [1:0] dispatch_fu = '0;
  logic [4:0] dispatch_rs1 = '0, dispatch_rs2 = '0, dispatch_rd = '0;
  logic [2:0] issue_ack = '0, wb_valid = '0;
  logic       dispatch_ready, fust_en;
  logic [1:0] fust_fu;
  logic [2:0] busy, issue_valid;
  logic [5:0] t1, t2;

  sb_scalar_tracker dut (
    .CLK(CLK), .nRST(nRST), .dispatch_valid(dispatch_valid), .dispatch_fu(dispatch_fu),
    .dispatch_rs1(dispatch_rs1), .dispatch_rs2(dispatch_rs2), .dispatch_rd(dispatch_rd),
    .dispatch_rd_we(dispatch_rd_we), .dispatch_ready(dispatch_ready), .fust_en(fust_en),
    .fust_fu(fust_fu), .busy(busy), .t1(t1), .t2(t2), .issue_valid(issue_valid),
    .issue_ack(issue_ack), .wb_valid(wb_valid), .flush(flush)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic rdy, en;
    logic [1:0] fu;
    logic [2:0] busy, iv;
    logic [5:0] t1, t2;
  } exp_t;
  exp_t q[$];
  int checks = 0, passed = 0;

  // model: which FU (1-based) will produce each register; per FU occupancy, issued flag, pending producers
  int m_rst[32];
  bit [2:0] m_busy, m_exec;
  int m_s1[3], m_s2[3];

  function automatic void model_clear();
    foreach (m_rst[r]) m_rst[r] = 0;
    m_busy = '0;
    m_exec = '0;
    for (int k = 0; k < 3; k++) begin m_s1[k] = 0; m_s2[k] = 0; end
  endfunction

  function automatic bit [2:0] model_iv();
    bit [2:0] v;
    for (int k = 0; k < 3; k++) v[k] = m_busy[k] && !m_exec[k] && m_s1[k] == 0 && m_s2[k] == 0;
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
  endtask

  task automatic cycle(input bit d, input int f, input int rs1, input int rs2, input int rd,
                       input bit we, input bit [2:0] ack, input bit [2:0] wb, input bit fl);
    exp_t e;
    bit rdy;
    int s1, s2;
    @(negedge CLK);
    dispatch_valid = d; dispatch_fu = 2'(f); dispatch_rs1 = 5'(rs1); dispatch_rs2 = 5'(rs2);
    dispatch_rd = 5'(rd); dispatch_rd_we = we; issue_ack = ack; wb_valid = wb; flush = fl;
    rdy = !m_busy[f] && !fl && !(we && rd != 0 && m_rst[rd] != 0);
    e.rdy = rdy; e.en = d && rdy; e.fu = 2'(f); e.busy = m_busy; e.iv = model_iv();
    for (int k = 0; k < 3; k++) begin
      e.t1[k*2 +: 2] = 2'(m_s1[k]);
      e.t2[k*2 +: 2] = 2'(m_s2[k]);
    end
    #1 q.push_back(e);
    if (fl) model_clear();
    else begin
      s1 = rs1 != 0 ? m_rst[rs1] : 0;
      s2 = rs2 != 0 ? m_rst[rs2] : 0;
      if (s1 != 0 && wb[s1-1]) s1 = 0;
      if (s2 != 0 && wb[s2-1]) s2 = 0;
      for (int k = 0; k < 3; k++) if (wb[k]) begin
        m_busy[k] = 0;
        m_exec[k] = 0;
        for (int j = 0; j < 3; j++) begin
          if (m_s1[j] == k + 1) m_s1[j] = 0;
          if (m_s2[j] == k + 1) m_s2[j] = 0;
        end
        foreach (m_rst[r]) if (m_rst[r] == k + 1) m_rst[r] = 0;
      end
      for (int k = 0; k < 3; k++) if (ack[k]) m_exec[k] = 1;
      if (d && rdy) begin
        m_busy[f] = 1; m_exec[f] = 0; m_s1[f] = s1; m_s2[f] = s2;
        if (we && rd != 0) m_rst[rd] = f + 1;
      end
    end
  endtask

  task automatic reset_dut();
    exp_t e;
    @(negedge CLK);
    nRST = 0;
    dispatch_valid = 0; dispatch_fu = '0; dispatch_rs1 = '0; dispatch_rs2 = '0; dispatch_rd = '0;
    dispatch_rd_we = 0; issue_ack = '0; wb_valid = '0; flush = 0;
    model_clear();
    e = '0;
    e.rdy = 1'b1;
    #1 q.push_back(e);
    #3 nRST = 1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      #3;
      while (q.size() > 0) begin
        e = q.pop_front();
        check("dispatch_ready", 8'(dispatch_ready), 8'(e.rdy));
        check("fust_en", 8'(fust_en), 8'(e.en));
        check("fust_fu", 8'(fust_fu), 8'(e.fu));
        check("busy", 8'(busy), 8'(e.busy));
        check("issue_valid", 8'(issue_valid), 8'(e.iv));
        check("t1", 8'(t1), 8'(e.t1));
        check("t2", 8'(t2), 8'(e.t2));
      end
    end
  end

  initial begin : driver
    bit [2:0] iv, ack, wb;
    reset_dut();
    cycle(1, 0, 0, 0, 5, 1, 3'b000, 3'b000, 0);
    cycle(1, 1, 5, 0, 9, 1, 3'b001, 3'b000, 0);
    cycle(1, 2, 0, 5, 0, 0, 3'b000, 3'b001, 0);
    cycle(1, 0, 0, 0, 9, 1, 3'b000, 3'b000, 0);
    cycle(1, 0, 0, 0, 0, 1, 3'b000, 3'b000, 0);
    cycle(1, 1, 3, 4, 6, 1, 3'b000, 3'b000, 1);
    cycle(0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 0);
    for (int i = 0; i < 2500; i++) begin
      if (i == 1200) reset_dut();
      iv = model_iv();
      for (int k = 0; k < 3; k++) begin
        ack[k] = iv[k] && $urandom_range(0, 1) == 1;
        wb[k] = m_busy[k] && m_exec[k] && $urandom_range(0, 2) == 0;
      end
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2), $urandom_range(0, 7),
            $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 3) != 0,
            ack, wb, $urandom_range(0, 39) == 0);
    end
    @(negedge CLK);
    #4;
    checks++;
    if (q.size() == 0) passed++;
    else $display("FAIL drain actual=%0d required=0", q.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "timeout");
  end
endmodule
